imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 124 ++++++++++++
 tb/tb_imem_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit instruction words from a valid/ready source into
// a byte-wide instruction memory, big-endian, starting at a word-aligned base.
// Each accepted word takes four write cycles plus one accept cycle.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  S_IDLE   | waiting for start; word_count/overflow hold last session
//  S_ACCEPT | word_ready high, waiting for word_valid
//  S_WRITE  | emitting the captured word one byte per cycle (idx 0..3)
//  S_DONE   | one-cycle done pulse, then back to S_IDLE
module imem_loader #(
    parameter int MEM_BYTES = 32,
    localparam int AW = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          word_valid,
    input  logic [31:0]   word_data,
    input  logic          word_last,
    output logic          word_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          busy,
    output logic          done,
    output logic [3:0]    word_count,
    output logic          overflow
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        state_q;
    logic [AW-1:0] ptr_q;
    logic [1:0]    idx_q;
    logic [31:0]   word_q;
    logic          last_q;
    logic [3:0]    count_q;
    logic          ovf_q;

    logic [AW-1:0] ptr_d;
    logic          ptr_wrap;
    logic [3:0]    count_d;
    logic [7:0]    byte_sel;

    // Next word pointer (modulo memory size), wrap flag and saturating count.
    always_comb begin
        {ptr_wrap, ptr_d} = {1'b0, ptr_q} + (AW+1)'(4);
        count_d = (count_q == 4'hF) ? count_q : count_q + 4'd1;
        case (idx_q)
            2'd0:    byte_sel = word_q[31:24];
            2'd1:    byte_sel = word_q[23:16];
            2'd2:    byte_sel = word_q[15:8];
            default: byte_sel = word_q[7:0];
        endcase
    end

    // Main sequencer: session setup, word capture, byte stepping, wrap tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ACCEPT;
                        ptr_q   <= start_addr & ~AW'(3);
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (word_valid) begin
                        word_q  <= word_data;
                        last_q  <= word_last;
                        idx_q   <= '0;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (idx_q == 2'd3) begin
                        ptr_q   <= ptr_d;
                        count_q <= count_d;
                        // Only a wrap that still has words to come is an overflow.
                        if (ptr_wrap && !last_q) begin
                            ovf_q <= 1'b1;
                        end
                        state_q <= last_q ? S_DONE : S_ACCEPT;
                    end else begin
                        idx_q <= idx_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded straight from flops so reset clears them without a clock.
    always_comb begin
        word_ready = (state_q == S_ACCEPT);
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        mem_we     = (state_q == S_WRITE);
        mem_addr   = mem_we ? (ptr_q | AW'(idx_q)) : '0;
        mem_wdata  = mem_we ? byte_sel : 8'h00;
        word_count = count_q;
        overflow   = ovf_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: stimulus pushes expected byte writes and done results
// into queues; a negedge monitor pops and compares whenever the DUT writes or
// pulses done.
module tb_imem_loader;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic          word_valid;
    logic [31:0]   word_data;
    logic          word_last;
    logic          word_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          done;
    logic [3:0]    word_count;
    logic          overflow;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        logic [3:0] cnt;
        logic       ovf;
    } dn_t;

    wr_t  wr_q[$];
    dn_t  dn_q[$];
    int   sess_ptr;
    int   model_cnt;
    logic model_ovf;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    imem_loader #(.MEM_BYTES(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_last  (word_last),
        .word_ready (word_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .overflow   (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: compares every byte strobe and every done pulse against the queues.
    always @(negedge clk) begin
        wr_t e;
        dn_t d;
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                fail_now($sformatf("unexpected_write addr=0x%0h data=0x%0h", mem_addr, mem_wdata));
            end else begin
                e = wr_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", 32'(mem_wdata), 32'(e.data));
            end
        end else begin
            chk("idle_addr", 32'(mem_addr), 32'd0);
            chk("idle_wdata", 32'(mem_wdata), 32'd0);
        end
        if (done) begin
            if (prev_done) fail_now("done_longer_than_one_cycle");
            if (dn_q.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                d = dn_q.pop_front();
                chk("done_word_count", 32'(word_count), 32'(d.cnt));
                chk("done_overflow", 32'(overflow), 32'(d.ovf));
                chk("done_busy", 32'(busy), 32'd1);
            end
        end
        prev_done = done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: words land at base+4k mod 32; overflow iff a wrap occurs before the last word.
    task automatic begin_session(input logic [4:0] addr, input int n, input bit expect_done);
        dn_t d;
        sess_ptr  = int'(addr) & 28;
        model_cnt = (n > 15) ? 15 : n;
        model_ovf = ((sess_ptr + 4 * (n - 1)) >= 32);
        if (expect_done) begin
            d.cnt = 4'(model_cnt);
            d.ovf = model_ovf;
            dn_q.push_back(d);
        end
        start      = 1'b1;
        start_addr = addr;
        @(negedge clk);
        start      = 1'b0;
        start_addr = 5'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("ready_after_start", 32'(word_ready), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] data, input logic last, output int waited);
        wr_t e;
        for (int i = 0; i < 4; i++) begin
            e.addr = 5'((sess_ptr + i) % 32);
            e.data = 8'(data >> (24 - 8 * i));
            wr_q.push_back(e);
        end
        sess_ptr   = (sess_ptr + 4) % 32;
        word_valid = 1'b1;
        word_data  = data;
        word_last  = last;
        waited     = 0;
        while (!word_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!word_ready) fail_now("handshake_timeout");
        @(negedge clk);
        word_valid = 1'b0;
        word_data  = $urandom;
        word_last  = 1'($urandom);
        chk("ready_low_in_write", 32'(word_ready), 32'd0);
        chk("we_after_handshake", 32'(mem_we), 32'd1);
    endtask

    task automatic end_session();
        int w = 0;
        while (!done && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("done_latency", 32'(w), 32'd4);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(word_ready), 32'd0);
        wait_neg(3);
        chk("hold_word_count", 32'(word_count), 32'(model_cnt));
        chk("hold_overflow", 32'(overflow), 32'(model_ovf));
    endtask

    initial begin
        int w;
        int n;
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        word_valid = 1'b0;
        word_data  = '0;
        word_last  = 1'b0;
        wait_neg(3);
        chk("rst_ready", 32'(word_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Start on the very first edge after reset release, single last word at 0.
        reset = 1'b0;
        begin_session(5'd0, 1, 1'b1);
        send_word(32'h3653_0001, 1'b1, w);
        end_session();

        // Two back-to-back words filling the top of memory; the last word wraps cleanly.
        begin_session(5'd24, 2, 1'b1);
        send_word(32'h2272_0004, 1'b0, w);
        send_word(32'h0000_0008, 1'b1, w);
        chk("b2b_ready_gap", 32'(w), 32'd4);
        end_session();

        // Wrap with a word still pending sets overflow, which then holds in idle.
        begin_session(5'd28, 2, 1'b1);
        send_word(32'hDEAD_BEEF, 1'b0, w);
        send_word(32'hCAFE_F00D, 1'b1, w);
        end_session();
        wait_neg(5);
        chk("ovf_sticky_idle", 32'(overflow), 32'd1);

        // Unaligned base address is rounded down to the word.
        begin_session(5'd5, 1, 1'b1);
        send_word(32'h0102_0304, 1'b1, w);
        end_session();

        // Stalled source, then start pulses while writing.
        begin_session(5'd8, 2, 1'b1);
        repeat (10) begin
            @(negedge clk);
            chk("stall_ready", 32'(word_ready), 32'd1);
            chk("stall_busy", 32'(busy), 32'd1);
        end
        send_word(32'h1122_3344, 1'b0, w);
        start      = 1'b1;
        start_addr = 5'd20;
        wait_neg(2);
        start      = 1'b0;
        send_word(32'h5566_7788, 1'b1, w);
        end_session();

        // Long session saturates word_count.
        begin_session(5'($urandom), 17, 1'b1);
        for (int k = 0; k < 17; k++) send_word($urandom, (k == 16), w);
        end_session();

        // Randomized sessions with random source gaps.
        repeat (8) begin
            n = $urandom_range(1, 6);
            begin_session(5'($urandom), n, 1'b1);
            for (int k = 0; k < n; k++) begin
                wait_neg($urandom_range(0, 3));
                send_word($urandom, (k == n - 1), w);
            end
            end_session();
        end

        // Reset after the second byte strobe abandons the word without a done pulse.
        begin_session(5'd16, 1, 1'b0);
        send_word(32'hA1B2_C3D4, 1'b1, w);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_we", 32'(mem_we), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("abandoned_bytes", 32'(wr_q.size()), 32'd2);
        wr_q.delete();
        wait_neg(2);
        reset = 1'b0;
        wait_neg(6);
        chk("post_rst_count", 32'(word_count), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        begin_session(5'd12, 2, 1'b1);
        send_word(32'h0BAD_F00D, 1'b0, w);
        send_word(32'h1234_5678, 1'b1, w);
        end_session();

        wait_neg(5);
        chk("writes_drained", 32'(wr_q.size()), 32'd0);
        chk("dones_drained", 32'(dn_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
